stream_acc_mc: RTL and testbench
================================

// Module: stream_acc_mc
// PURPOSE
//  Multi-channel streaming block accumulator, successor of the single-lane packet accumulator.
//  Sums AMOUNT_OF_DATA consecutive accepted samples per lane into one result (sum or mean).
//  Flags the last packet of every group of AMOUNT_OF_PACKET packets.
//  Sits between a sample source and a downstream consumer; both sides use valid/ready handshakes.
// PARAMETERS
//  WIDTH             8     sample width per lane
//  CHANNELS          2     number of parallel lanes; all lanes share the valid/ready handshake
//  AMOUNT_OF_DATA    16    samples per packet; must be a power of 2 and >= 2
//  AMOUNT_OF_PACKET  8     packets per group; must be >= 1
//  SIGNED            0     1 = two's-complement samples, with sign extension and arithmetic shift
//  AVERAGE           0     1 = output the mean (sum >>> log2(AMOUNT_OF_DATA)); 0 = output the raw sum
//  OUT_W is a localparam = WIDTH + $clog2(AMOUNT_OF_DATA).
// PORTS
//  clk       in   1               clock, rising edge
//  rst       in   1               asynchronous reset, active-low
//  sync_clr  in   1               synchronous clear of the partial packet and the packet counter
//  data_in   in   CHANNELS*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH]
//  valid_in  in   1               input sample valid
//  ready_in  out  1               block can accept an input sample
//  data_o    out  CHANNELS*OUT_W  lane k occupies bits [k*OUT_W +: OUT_W]
//  valid_o   out  1               result valid
//  ready_o   in   1               consumer accepts the result
//  last_o    out  1               result belongs to packet index AMOUNT_OF_PACKET-1 of its group
// BEHAVIOUR
//  - Reset values: valid_o=0, data_o=0, last_o=0, sample counter=0, packet counter=0, accumulators=0.
//    ready_in=1 while out of reset.
//  - Input accept: a sample is taken on a cycle with valid_in && ready_in. Gaps in valid_in are allowed;
//    idle cycles leave all state unchanged.
//  - Sample counter runs 0..AMOUNT_OF_DATA-1.
//    At count 0 the accumulator loads the extended sample; at other counts it adds the extended sample.
//    Extension is sign extension if SIGNED=1, zero extension otherwise, to OUT_W bits.
//  - Final sample (count = AMOUNT_OF_DATA-1):
//    acc + sample is written straight into the output register; valid_o rises on the next cycle,
//    so latency is 1 cycle from the final accept; the counter wraps to 0.
//    last_o is set to (packet counter == AMOUNT_OF_PACKET-1); the packet counter then increments
//    and wraps to 0.
//  - The sum cannot overflow: OUT_W holds the full-scale sum.
//  - AVERAGE=1: result = sum >>> log2(AMOUNT_OF_DATA), flooring toward -inf when SIGNED=1.
//    It is sign- or zero-extended back to OUT_W.
//  - Output handshake: the result transfers on valid_o && ready_o.
//    data_o and last_o are held stable while valid_o && !ready_o.
//  - Backpressure: ready_in = !(count == AMOUNT_OF_DATA-1 && valid_o && !ready_o).
//    Non-final samples are always accepted. A new result may load on the same cycle the old one
//    transfers; this gives full throughput.
//  - sync_clr (priority over input in the same cycle): the sample counter and packet counter go to 0,
//    and any partial accumulation is discarded. A sample presented that cycle is dropped.
//    A pending valid_o result is unaffected.
//  - Reset mid-operation: all state is forced to reset values immediately, with no wait for a clock
//    edge. A partial packet is lost and any pending output is dropped.
// STRUCTURE
//  - Package stream_acc_pkg:
//    function acc_w(width, n) returning width + $clog2(n);
//    typedef enum {ACC_SUM, ACC_MEAN};
//    elaboration checks that AMOUNT_OF_DATA is a power of 2.
//  - Sub-module stream_acc_lane: per-lane extend / accumulate / optional shift.
//    Instantiated CHANNELS times in a generate loop.
//  - The sample counter, packet counter and handshake logic are shared in the top module.
// TESTING
//  (W=8, CH=2, N=4, P=3 unless noted)
//  1 SIGNED=0 AVERAGE=0: lane0 1,2,3,4 and lane1 255,255,255,255, back-to-back
//    -> one cycle after the 4th accept: valid_o=1, lane0=10, lane1=1020, last_o=0.
//  2 SIGNED=1 AVERAGE=1: lane0 -1,-2,-3,-4 -> -3 (floor of -2.5).
//    Lane0 127x4 -> 127; lane0 -128x4 -> -128.
//  3 ready_o=0 with packets streamed continuously
//    -> first result held stable; ready_in drops only on the 2nd packet's final sample.
//    Raise ready_o -> both results delivered in order, no sample lost.
//  4 9 packets with ready_o=1 -> last_o=1 on results 3, 6 and 9 only; packet counter wraps.
//  5 accept 2 samples, pulse sync_clr, then send 1,1,1,1 on lane0 -> lane0 result=4.
//    A sample presented in the sync_clr cycle is ignored.
//  6 drop rst mid-packet while valid_o=1 -> valid_o=0 asynchronously.
//    After release, a full packet of 2s gives 8 (no residue).
//    Also insert random valid_in gaps in scenario 1 -> results identical.

Source files
------------

// File: rtl/stream_acc_pkg.sv
// Shared types and elaboration helpers for the multi-channel stream accumulator.
package stream_acc_pkg;

  typedef enum logic {
    ACC_SUM  = 1'b0,
    ACC_MEAN = 1'b1
  } acc_mode_e;

  // Output width that holds a full-scale sum of n samples of the given width.
  function automatic int unsigned acc_w(input int unsigned width, input int unsigned n);
    return width + $clog2(n);
  endfunction

  function automatic bit is_pow2(input int unsigned n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/stream_acc_mc_if.sv
// Sample-in / result-out valid-ready bundle shared by all lanes.
interface stream_acc_mc_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned OUT_W    = 12
) ();

  logic [CHANNELS*WIDTH-1:0] data_in;
  logic                      valid_in;
  logic                      ready_in;
  logic [CHANNELS*OUT_W-1:0] data_o;
  logic                      valid_o;
  logic                      ready_o;
  logic                      last_o;

  modport slave (
    input  data_in, valid_in, ready_o,
    output ready_in, data_o, valid_o, last_o
  );

  modport master (
    output data_in, valid_in, ready_o,
    input  ready_in, data_o, valid_o, last_o
  );

endinterface

// File: rtl/stream_acc_lane.sv
// One lane: extends each sample, accumulates a packet, and registers the sum or mean.
module stream_acc_lane
  import stream_acc_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned OUT_W  = 12,
  parameter bit          SIGNED = 1'b0,
  parameter acc_mode_e   MODE   = ACC_SUM
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync_clr,
  input  logic             take,
  input  logic             first,
  input  logic             fin,
  input  logic [WIDTH-1:0] din,
  output logic [OUT_W-1:0] dout
);

  localparam int unsigned LOG2N = OUT_W - WIDTH;

  logic [OUT_W-1:0] acc_q;
  logic [OUT_W-1:0] ext_c;
  logic [OUT_W-1:0] sum_c;
  logic [OUT_W-1:0] mean_c;
  logic [OUT_W-1:0] res_c;
  logic             sign_c;
  logic             fill_c;

  // Extend, add, and derive the floored mean by an arithmetic or logical shift.
  always_comb begin
    sign_c = SIGNED ? din[WIDTH-1] : 1'b0;
    ext_c  = {{LOG2N{sign_c}}, din};
    sum_c  = (first ? '0 : acc_q) + ext_c;
    fill_c = SIGNED ? sum_c[OUT_W-1] : 1'b0;
    mean_c = {{LOG2N{fill_c}}, sum_c[OUT_W-1:LOG2N]};
    res_c  = (MODE == ACC_MEAN) ? mean_c : sum_c;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
      dout  <= '0;
    end else begin
      if (sync_clr) begin
        acc_q <= '0;
      end else if (take) begin
        acc_q <= fin ? '0 : sum_c;
      end
      // Final sample bypasses the accumulator straight into the result register.
      if (take && fin) begin
        dout <= res_c;
      end
    end
  end

endmodule

// File: rtl/stream_acc_mc.sv
// Multi-lane streaming packet accumulator with group-last flagging and output backpressure.
module stream_acc_mc
  import stream_acc_pkg::*;
#(
  parameter int unsigned WIDTH            = 8,
  parameter int unsigned CHANNELS         = 2,
  parameter int unsigned AMOUNT_OF_DATA   = 16,
  parameter int unsigned AMOUNT_OF_PACKET = 8,
  parameter bit          SIGNED           = 1'b0,
  parameter bit          AVERAGE          = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sync_clr,
  stream_acc_mc_if.slave bus
);

  localparam int unsigned OUT_W = acc_w(WIDTH, AMOUNT_OF_DATA);
  localparam int unsigned CNT_W = $clog2(AMOUNT_OF_DATA);
  localparam int unsigned PKT_W = (AMOUNT_OF_PACKET > 1) ? $clog2(AMOUNT_OF_PACKET) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AMOUNT_OF_DATA - 1);
  localparam logic [PKT_W-1:0] PKT_LAST = PKT_W'(AMOUNT_OF_PACKET - 1);
  localparam acc_mode_e MODE = AVERAGE ? ACC_MEAN : ACC_SUM;

  if (!is_pow2(AMOUNT_OF_DATA)) begin : g_bad_data
    $error("stream_acc_mc: AMOUNT_OF_DATA must be a power of 2 and >= 2");
  end
  if (AMOUNT_OF_PACKET < 1) begin : g_bad_packet
    $error("stream_acc_mc: AMOUNT_OF_PACKET must be >= 1");
  end

  logic [CNT_W-1:0]          cnt_q;
  logic [PKT_W-1:0]          pkt_q;
  logic                      valid_q;
  logic                      last_q;
  logic [CHANNELS*OUT_W-1:0] data_q;
  logic                      ready_c;
  logic                      take_c;
  logic                      first_c;
  logic                      fin_c;

  // Only a final sample can stall, and only while the previous result is still unclaimed.
  always_comb begin
    ready_c = 1'b1;
    take_c  = 1'b0;
    first_c = 1'b0;
    fin_c   = 1'b0;
    ready_c = !((cnt_q == CNT_LAST) && valid_q && !bus.ready_o);
    take_c  = bus.valid_in && ready_c && !sync_clr;
    first_c = (cnt_q == '0);
    fin_c   = take_c && (cnt_q == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      pkt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      if (sync_clr) begin
        cnt_q <= '0;
        pkt_q <= '0;
      end else if (take_c) begin
        cnt_q <= fin_c ? '0 : cnt_q + CNT_W'(1);
        if (fin_c) begin
          pkt_q <= (pkt_q == PKT_LAST) ? '0 : pkt_q + PKT_W'(1);
        end
      end
      // A new result may replace the old one in the cycle it transfers.
      if (fin_c) begin
        valid_q <= 1'b1;
        last_q  <= (pkt_q == PKT_LAST);
      end else if (bus.ready_o) begin
        valid_q <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    stream_acc_lane #(
      .WIDTH  (WIDTH),
      .OUT_W  (OUT_W),
      .SIGNED (SIGNED),
      .MODE   (MODE)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .sync_clr (sync_clr),
      .take     (take_c),
      .first    (first_c),
      .fin      (fin_c),
      .din      (bus.data_in[k*WIDTH +: WIDTH]),
      .dout     (data_q[k*OUT_W +: OUT_W])
    );
  end

  assign bus.ready_in = ready_c;
  assign bus.valid_o  = valid_q;
  assign bus.last_o   = last_q;
  assign bus.data_o   = data_q;

endmodule

// File: tb/tb_stream_acc_mc.sv
// Directed bench: unsigned-sum instance and signed-mean instance, W=8 CH=2 N=4 P=3.
module tb_stream_acc_mc;

  logic clk = 1'b0;
  logic rst;
  logic clr_u;
  logic clr_s;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  stream_acc_mc_if #(.WIDTH(8), .CHANNELS(2), .OUT_W(10)) bus_u ();
  stream_acc_mc_if #(.WIDTH(8), .CHANNELS(2), .OUT_W(10)) bus_s ();

  stream_acc_mc #(
    .WIDTH(8), .CHANNELS(2), .AMOUNT_OF_DATA(4), .AMOUNT_OF_PACKET(3),
    .SIGNED(1'b0), .AVERAGE(1'b0)
  ) dut_u (
    .clk(clk), .rst(rst), .sync_clr(clr_u), .bus(bus_u)
  );

  stream_acc_mc #(
    .WIDTH(8), .CHANNELS(2), .AMOUNT_OF_DATA(4), .AMOUNT_OF_PACKET(3),
    .SIGNED(1'b1), .AVERAGE(1'b1)
  ) dut_s (
    .clk(clk), .rst(rst), .sync_clr(clr_s), .bus(bus_s)
  );

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put_u(input logic [7:0] a, input logic [7:0] b);
    bus_u.data_in  = {b, a};
    bus_u.valid_in = 1'b1;
    @(posedge clk);
    #1;
    bus_u.valid_in = 1'b0;
  endtask

  task automatic put_s(input logic [7:0] a, input logic [7:0] b);
    bus_s.data_in  = {b, a};
    bus_s.valid_in = 1'b1;
    @(posedge clk);
    #1;
    bus_s.valid_in = 1'b0;
  endtask

  task automatic pulse_clr_u();
    clr_u = 1'b1;
    idle(1);
    clr_u = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_chk++;
    if (bus_u.valid_o !== 1'b0 || bus_u.last_o !== 1'b0 || bus_u.data_o !== 20'd0)
      $display("FAIL reset_outputs: got v=%b l=%b d=%h want v=0 l=0 d=0",
               bus_u.valid_o, bus_u.last_o, bus_u.data_o);
    else n_pass++;
    #5 rst = 1'b1;
    idle(1);
    n_chk++;
    if (bus_u.ready_in !== 1'b1 || bus_u.valid_o !== 1'b0)
      $display("FAIL reset_release: got rdy=%b v=%b want rdy=1 v=0", bus_u.ready_in, bus_u.valid_o);
    else n_pass++;
  endtask

  task automatic test_sum();
    put_u(8'd1, 8'd255);
    put_u(8'd2, 8'd255);
    put_u(8'd3, 8'd255);
    n_chk++;
    if (bus_u.valid_o !== 1'b0)
      $display("FAIL sum_early_valid: got %b want 0", bus_u.valid_o);
    else n_pass++;
    put_u(8'd4, 8'd255);
    n_chk++;
    if (bus_u.valid_o !== 1'b1 || bus_u.data_o !== {10'd1020, 10'd10} || bus_u.last_o !== 1'b0)
      $display("FAIL sum_result: got v=%b d=%h l=%b want v=1 d=%h l=0",
               bus_u.valid_o, bus_u.data_o, bus_u.last_o, {10'd1020, 10'd10});
    else n_pass++;
    idle(1);
    n_chk++;
    if (bus_u.valid_o !== 1'b0)
      $display("FAIL sum_drain: got v=%b want 0", bus_u.valid_o);
    else n_pass++;
  endtask

  task automatic test_gaps();
    for (int i = 1; i <= 4; i++) begin
      put_u(8'(i), 8'd255);
      if (i < 4) idle(int'($urandom_range(0, 2)));
    end
    n_chk++;
    if (bus_u.valid_o !== 1'b1 || bus_u.data_o !== {10'd1020, 10'd10} || bus_u.last_o !== 1'b0)
      $display("FAIL gaps_result: got v=%b d=%h l=%b want v=1 d=%h l=0",
               bus_u.valid_o, bus_u.data_o, bus_u.last_o, {10'd1020, 10'd10});
    else n_pass++;
    idle(1);
  endtask

  task automatic test_signed_mean();
    put_s(8'hFF, 8'd5);
    put_s(8'hFE, 8'd6);
    put_s(8'hFD, 8'd7);
    put_s(8'hFC, 8'd8);
    n_chk++;
    if (bus_s.valid_o !== 1'b1 || bus_s.data_o !== {10'd6, 10'h3FD})
      $display("FAIL mean_neg: got v=%b d=%h want v=1 d=%h", bus_s.valid_o, bus_s.data_o, {10'd6, 10'h3FD});
    else n_pass++;
    repeat (4) put_s(8'h7F, 8'd0);
    n_chk++;
    if (bus_s.data_o !== {10'd0, 10'h07F})
      $display("FAIL mean_max: got %h want %h", bus_s.data_o, {10'd0, 10'h07F});
    else n_pass++;
    repeat (4) put_s(8'h80, 8'd0);
    n_chk++;
    if (bus_s.data_o !== {10'd0, 10'h380})
      $display("FAIL mean_min: got %h want %h", bus_s.data_o, {10'd0, 10'h380});
    else n_pass++;
    idle(1);
  endtask

  task automatic test_back_to_back();
    pulse_clr_u();
    bus_u.ready_o = 1'b0;
    repeat (4) put_u(8'd1, 8'd2);
    repeat (3) begin
      n_chk++;
      if (bus_u.ready_in !== 1'b1)
        $display("FAIL bp_nonfinal_ready: got %b want 1", bus_u.ready_in);
      else n_pass++;
      put_u(8'd3, 8'd0);
    end
    bus_u.data_in  = {8'd0, 8'd3};
    bus_u.valid_in = 1'b1;
    #0;
    n_chk++;
    if (bus_u.ready_in !== 1'b0)
      $display("FAIL bp_final_stall: got ready_in=%b want 0", bus_u.ready_in);
    else n_pass++;
    idle(3);
    n_chk++;
    if (bus_u.ready_in !== 1'b0 || bus_u.valid_o !== 1'b1 || bus_u.data_o !== {10'd8, 10'd4})
      $display("FAIL bp_hold: got rdy=%b v=%b d=%h want rdy=0 v=1 d=%h",
               bus_u.ready_in, bus_u.valid_o, bus_u.data_o, {10'd8, 10'd4});
    else n_pass++;
    bus_u.ready_o = 1'b1;
    #0;
    n_chk++;
    if (bus_u.ready_in !== 1'b1 || bus_u.last_o !== 1'b0)
      $display("FAIL bp_release: got rdy=%b l=%b want rdy=1 l=0", bus_u.ready_in, bus_u.last_o);
    else n_pass++;
    @(posedge clk);
    #1;
    bus_u.valid_in = 1'b0;
    n_chk++;
    if (bus_u.valid_o !== 1'b1 || bus_u.data_o !== {10'd0, 10'd12} || bus_u.last_o !== 1'b0)
      $display("FAIL bp_second: got v=%b d=%h l=%b want v=1 d=%h l=0",
               bus_u.valid_o, bus_u.data_o, bus_u.last_o, {10'd0, 10'd12});
    else n_pass++;
    idle(1);
    n_chk++;
    if (bus_u.valid_o !== 1'b0)
      $display("FAIL bp_drain: got v=%b want 0", bus_u.valid_o);
    else n_pass++;
  endtask

  task automatic test_last();
    pulse_clr_u();
    for (int r = 1; r <= 9; r++) begin
      repeat (4) put_u(8'(r), 8'd0);
      n_chk++;
      if (bus_u.valid_o !== 1'b1 || bus_u.data_o !== {10'd0, 10'(4 * r)} || bus_u.last_o !== (r % 3 == 0))
        $display("FAIL last_pkt%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 r, bus_u.valid_o, bus_u.data_o, bus_u.last_o, {10'd0, 10'(4 * r)}, (r % 3 == 0));
      else n_pass++;
    end
  endtask

  task automatic test_sync_clr();
    put_u(8'd7, 8'd7);
    put_u(8'd7, 8'd7);
    clr_u          = 1'b1;
    bus_u.data_in  = {8'd9, 8'd100};
    bus_u.valid_in = 1'b1;
    idle(1);
    clr_u          = 1'b0;
    bus_u.valid_in = 1'b0;
    repeat (3) put_u(8'd1, 8'd0);
    n_chk++;
    if (bus_u.valid_o !== 1'b0)
      $display("FAIL clr_early_valid: got %b want 0", bus_u.valid_o);
    else n_pass++;
    put_u(8'd1, 8'd0);
    n_chk++;
    if (bus_u.valid_o !== 1'b1 || bus_u.data_o !== {10'd0, 10'd4})
      $display("FAIL clr_result: got v=%b d=%h want v=1 d=%h", bus_u.valid_o, bus_u.data_o, {10'd0, 10'd4});
    else n_pass++;
    idle(1);
  endtask

  task automatic test_reset_mid();
    bus_u.ready_o = 1'b0;
    repeat (4) put_u(8'd5, 8'd5);
    put_u(8'd9, 8'd9);
    put_u(8'd9, 8'd9);
    #2 rst = 1'b0;
    #1;
    n_chk++;
    if (bus_u.valid_o !== 1'b0 || bus_u.data_o !== 20'd0 || bus_u.ready_in !== 1'b1)
      $display("FAIL rst_async: got v=%b d=%h rdy=%b want v=0 d=0 rdy=1",
               bus_u.valid_o, bus_u.data_o, bus_u.ready_in);
    else n_pass++;
    rst = 1'b1;
    bus_u.ready_o = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) put_u(8'd2, 8'd0);
    n_chk++;
    if (bus_u.valid_o !== 1'b0)
      $display("FAIL rst_residue_valid: got %b want 0", bus_u.valid_o);
    else n_pass++;
    put_u(8'd2, 8'd0);
    n_chk++;
    if (bus_u.valid_o !== 1'b1 || bus_u.data_o !== {10'd0, 10'd8})
      $display("FAIL rst_result: got v=%b d=%h want v=1 d=%h", bus_u.valid_o, bus_u.data_o, {10'd0, 10'd8});
    else n_pass++;
    idle(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b0;
    clr_u          = 1'b0;
    clr_s          = 1'b0;
    bus_u.data_in  = '0;
    bus_u.valid_in = 1'b0;
    bus_u.ready_o  = 1'b1;
    bus_s.data_in  = '0;
    bus_s.valid_in = 1'b0;
    bus_s.ready_o  = 1'b1;
    test_reset();
    test_sum();
    test_gaps();
    test_signed_mean();
    test_back_to_back();
    test_last();
    test_sync_clr();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
